// File: rtl/abc_load_arb.sv
// abc_load_arb: round-robin scheduler that loads one requester's {a,b,c} value into shared capture flops, then holds the grant for a guard time
module abc_load_arb #(
  parameter int NREQ = 4,
  parameter int HOLD_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset_l,
  input  logic              arb_en,
  input  logic [NREQ-1:0]   req,
  input  logic [3*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   gnt,
  output logic              a,
  output logic              b,
  output logic              c,
  output logic              ld_done,
  output logic              busy
);
  localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1;
  typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;
  state_t state, nxt;
  logic [PW-1:0] rr_ptr, win, nxt_win;
  logic [7:0] hold_cnt;
  // descending scan so the requester closest to rr_ptr wins
  always_comb begin
    nxt_win = rr_ptr;
    for (int i = NREQ - 1; i >= 0; i--)
      if (req[(int'(rr_ptr) + i) % NREQ]) nxt_win = PW'((int'(rr_ptr) + i) % NREQ);
  end
  always_comb begin
    nxt = state;
    if (state == IDLE && arb_en && |req) nxt = LOAD;
    else if (state == LOAD) nxt = HOLD_CYCLES > 0 ? HOLD : IDLE;
    else if (state == HOLD && hold_cnt == 8'(HOLD_CYCLES)) nxt = IDLE;
  end
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      win      <= '0;
      hold_cnt <= '0;
      gnt      <= '0;
      ld_done  <= 1'b0;
      {a, b, c} <= 3'b001;
    end else begin
      state    <= nxt;
      ld_done  <= state == LOAD;
      hold_cnt <= nxt == HOLD ? hold_cnt + 8'd1 : 8'd0;
      if (state == IDLE && nxt == LOAD) begin
        win <= nxt_win;
        gnt <= NREQ'(1) << nxt_win;
      end
      if (state == LOAD) {a, b, c} <= req_data[3*int'(win) +: 3];
      if (state != IDLE && nxt == IDLE) begin
        gnt    <= '0;
        rr_ptr <= win == PW'(NREQ - 1) ? '0 : win + 1'b1;
      end
    end
  end
  assign busy = state != IDLE;
endmodule

// File: tb/tb_abc_load_arb.sv
// tb_abc_load_arb: checks two arbiters (guard 2 and guard 0) against a grant-level reference model
module tb_abc_load_arb;
  logic clk = 0, reset_l = 0, arb_en = 0;
  logic [3:0] req = '0;
  logic [11:0] req_data = '0;
  logic [3:0] gnt2, gnt0;
  logic a2, b2, c2, a0, b0, c0, ld2, ld0, busy2, busy0;
  int checks = 0, passes = 0;
  int h[2] = '{2, 0};
  logic [3:0] m_gnt[2];
  logic [2:0] m_abc[2];
  logic m_ld[2];
  int m_left[2], m_ptr[2], m_win[2];
  logic [3:0] o_gnt[2];
  logic [2:0] o_abc[2];
  logic o_ld[2], o_busy[2];

  abc_load_arb #(.NREQ(4), .HOLD_CYCLES(2)) u2 (.clk(clk), .reset_l(reset_l), .arb_en(arb_en), .req(req),
    .req_data(req_data), .gnt(gnt2), .a(a2), .b(b2), .c(c2), .ld_done(ld2), .busy(busy2));
  abc_load_arb #(.NREQ(4), .HOLD_CYCLES(0)) u0 (.clk(clk), .reset_l(reset_l), .arb_en(arb_en), .req(req),
    .req_data(req_data), .gnt(gnt0), .a(a0), .b(b0), .c(c0), .ld_done(ld0), .busy(busy0));

  assign o_gnt[0] = gnt2;
  assign o_gnt[1] = gnt0;
  assign o_abc[0] = {a2, b2, c2};
  assign o_abc[1] = {a0, b0, c0};
  assign o_ld[0] = ld2;
  assign o_ld[1] = ld0;
  assign o_busy[0] = busy2;
  assign o_busy[1] = busy0;

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_gnt[d] = '0; m_abc[d] = 3'b001; m_ld[d] = 0;
      m_left[d] = 0; m_ptr[d] = 0; m_win[d] = 0;
    end
  endtask

  // a grant occupies 1+guard cycles; the value is captured at the end of its first cycle
  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      m_ld[d] = 0;
      if (m_left[d] == 0) begin
        if (arb_en && |req) begin
          bit found = 0;
          for (int i = 0; i < 4; i++)
            if (!found && req[(m_ptr[d] + i) % 4]) begin
              found = 1;
              m_win[d] = (m_ptr[d] + i) % 4;
            end
          m_left[d] = 1 + h[d];
          m_gnt[d] = 4'b0001 << m_win[d];
        end
      end else begin
        if (m_left[d] == 1 + h[d]) begin
          m_abc[d] = req_data[3*m_win[d] +: 3];
          m_ld[d] = 1;
        end
        m_left[d]--;
        if (m_left[d] == 0) begin
          m_gnt[d] = '0;
          m_ptr[d] = (m_win[d] + 1) % 4;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset_l) model_step(); else model_reset();
    #1;
  endtask

  task automatic do_reset();
    reset_l = 0;
    model_reset();
    @(negedge clk);
    reset_l = 1;
  endtask

  task automatic test_reset();
    tick();
    #2 reset_l = 0;
    model_reset();
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++; if (o_abc[d] !== 3'b001) $display("FAIL reset_abc dut%0d: got %b want 001", d, o_abc[d]); else passes++;
      checks++; if (o_gnt[d] !== 4'b0) $display("FAIL reset_gnt dut%0d: got %b want 0000", d, o_gnt[d]); else passes++;
      checks++; if ({o_busy[d], o_ld[d]} !== 2'b00) $display("FAIL reset_busy_ld dut%0d: got %b want 00", d, {o_busy[d], o_ld[d]}); else passes++;
    end
    @(negedge clk);
    reset_l = 1;
  endtask

  task automatic test_single();
    do_reset();
    arb_en = 1; req = 4'b0100; req_data = 12'b000_101_000_000;
    tick();
    checks++; if (gnt2 !== 4'b0100 || ld2 !== 0) $display("FAIL single_n1 got gnt=%b ld=%b want 0100/0", gnt2, ld2); else passes++;
    req = 4'b0000;
    tick();
    checks++; if ({a2, b2, c2} !== 3'b101 || ld2 !== 1 || gnt2 !== 4'b0100) $display("FAIL single_n2 got abc=%b ld=%b gnt=%b want 101/1/0100", {a2, b2, c2}, ld2, gnt2); else passes++;
    tick();
    checks++; if (gnt2 !== 4'b0100 || ld2 !== 0 || busy2 !== 1) $display("FAIL single_n3 got gnt=%b ld=%b busy=%b want 0100/0/1", gnt2, ld2, busy2); else passes++;
    tick();
    checks++; if (gnt2 !== 4'b0000 || busy2 !== 0) $display("FAIL single_n4 got gnt=%b busy=%b want 0000/0", gnt2, busy2); else passes++;
  endtask

  task automatic test_round_robin();
    do_reset();
    arb_en = 1; req = 4'b1111; req_data = {3'd3, 3'd2, 3'd1, 3'd0};
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++; if (gnt2 !== 4'b0001 << (k % 4)) $display("FAIL rr_gnt%0d got %b want %b", k, gnt2, 4'b0001 << (k % 4)); else passes++;
      tick();
      checks++; if ({a2, b2, c2} !== 3'(k % 4)) $display("FAIL rr_abc%0d got %0d want %0d", k, {a2, b2, c2}, k % 4); else passes++;
      tick();
      tick();
      checks++; if (gnt2 !== 4'b0) $display("FAIL rr_gap%0d got %b want 0000", k, gnt2); else passes++;
    end
  endtask

  task automatic test_wrap_skip();
    do_reset();
    arb_en = 1; req = 4'b0100;
    tick();
    req = 4'b0011;
    repeat (3) tick();
    tick();
    checks++; if (gnt2 !== 4'b0001) $display("FAIL wrap_gnt got %b want 0001", gnt2); else passes++;
    repeat (3) tick();
    tick();
    checks++; if (gnt2 !== 4'b0010) $display("FAIL skip_gnt got %b want 0010", gnt2); else passes++;
  endtask

  task automatic test_arb_en();
    do_reset();
    arb_en = 0; req = 4'b0001; req_data = 12'h007;
    repeat (3) begin
      tick();
      checks++; if (gnt2 !== 4'b0 || busy2 !== 0) $display("FAIL en_off got gnt=%b busy=%b want 0000/0", gnt2, busy2); else passes++;
    end
    arb_en = 1;
    tick();
    checks++; if (gnt2 !== 4'b0001) $display("FAIL en_on got %b want 0001", gnt2); else passes++;
    arb_en = 0;
    tick();
    checks++; if (ld2 !== 1 || {a2, b2, c2} !== 3'b111) $display("FAIL en_fall_load got ld=%b abc=%b want 1/111", ld2, {a2, b2, c2}); else passes++;
    repeat (3) tick();
    checks++; if (gnt2 !== 4'b0 || busy2 !== 0) $display("FAIL en_fall_nogrant got gnt=%b busy=%b want 0000/0", gnt2, busy2); else passes++;
    arb_en = 1;
  endtask

  task automatic test_hold0();
    do_reset();
    arb_en = 1; req = 4'b0011; req_data = {6'b0, 3'b011, 3'b110};
    tick();
    checks++; if (gnt0 !== 4'b0001) $display("FAIL h0_g0 got %b want 0001", gnt0); else passes++;
    tick();
    checks++; if (gnt0 !== 4'b0 || ld0 !== 1 || {a0, b0, c0} !== 3'b110) $display("FAIL h0_l0 got gnt=%b ld=%b abc=%b want 0000/1/110", gnt0, ld0, {a0, b0, c0}); else passes++;
    tick();
    checks++; if (gnt0 !== 4'b0010) $display("FAIL h0_g1 got %b want 0010", gnt0); else passes++;
    tick();
    checks++; if (ld0 !== 1 || {a0, b0, c0} !== 3'b011) $display("FAIL h0_l1 got ld=%b abc=%b want 1/011", ld0, {a0, b0, c0}); else passes++;
    tick();
    checks++; if (gnt0 !== 4'b0001) $display("FAIL h0_g2 got %b want 0001", gnt0); else passes++;
    reset_l = 0;
    model_reset();
    #1;
    checks++; if (gnt0 !== 4'b0 || {a0, b0, c0} !== 3'b001) $display("FAIL h0_rst got gnt=%b abc=%b want 0000/001", gnt0, {a0, b0, c0}); else passes++;
    #1 reset_l = 1;
    tick();
    checks++; if (ld0 !== 0 || {a0, b0, c0} !== 3'b001 || gnt0 !== 4'b0001) $display("FAIL h0_noload got ld=%b abc=%b gnt=%b want 0/001/0001", ld0, {a0, b0, c0}, gnt0); else passes++;
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      arb_en = $urandom_range(0, 7) != 0;
      req = 4'($urandom);
      req_data = 12'($urandom);
      tick();
      for (int d = 0; d < 2; d++) begin
        checks++; if (o_gnt[d] !== m_gnt[d]) $display("FAIL rnd_gnt dut%0d cyc%0d got %b want %b", d, n, o_gnt[d], m_gnt[d]); else passes++;
        checks++; if (o_abc[d] !== m_abc[d]) $display("FAIL rnd_abc dut%0d cyc%0d got %b want %b", d, n, o_abc[d], m_abc[d]); else passes++;
        checks++; if (o_ld[d] !== m_ld[d]) $display("FAIL rnd_ld dut%0d cyc%0d got %b want %b", d, n, o_ld[d], m_ld[d]); else passes++;
        checks++; if (o_busy[d] !== (m_left[d] != 0)) $display("FAIL rnd_busy dut%0d cyc%0d got %b want %b", d, n, o_busy[d], m_left[d] != 0); else passes++;
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_wrap_skip();
    test_arb_en();
    test_hold0();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
